// File: rtl/alu_pkg.sv
// Shared types and the logic-unit evaluation function for the ALU command issuer.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } state_t;

  function automatic logic [ALU_WIDTH-1:0] alu_eval(input op_t op,
                                                    input logic [ALU_WIDTH-1:0] a,
                                                    input logic [ALU_WIDTH-1:0] b);
    logic [ALU_WIDTH-1:0] x;
    case (op)
      OP_AND:  x = a & b;
      OP_OR:   x = a | b;
      OP_XOR:  x = a ^ b;
      default: x = ~(a & b);
    endcase
    return x;
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational reference logic unit: x = op(a, b).
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [1:0]           op,
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  output logic [ALU_WIDTH-1:0] x
);

  assign x = alu_eval(op_t'(op), a, b);

endmodule

// File: rtl/alu_cmd_issuer.sv
// Iterating request initiator for the 2-bit-opcode logic unit.
// Optional response self-check is built when ALU_CHK_EN is defined.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_load,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [1:0]       req_op,
  output logic [WIDTH-1:0] req_a,
  output logic [WIDTH-1:0] req_b,
  input  logic             rsp_valid,
  input  logic [WIDTH-1:0] rsp_x,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [1:0]       state_dbg
`ifdef ALU_CHK_EN
  ,
  output logic             chk_mismatch,
  output logic [WIDTH-1:0] chk_bad_x
`endif
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  // Valid/ready: a transfer happens in any cycle where valid && ready are both
  // high; once valid rises its payload is held unchanged until that cycle.
  state_t           state, state_n;
  op_t              op_q, op_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] b_q, b_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [TMO_W-1:0] tmo, tmo_n;
  logic             err_q, err_n;
  logic             capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= OP_AND;
      acc   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      tmo   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      op_q  <= op_n;
      acc   <= acc_n;
      b_q   <= b_n;
      cnt   <= cnt_n;
      tmo   <= tmo_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    op_n    = op_q;
    acc_n   = acc;
    b_n     = b_q;
    cnt_n   = cnt;
    tmo_n   = tmo;
    err_n   = err_q;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          op_n  = op_t'(cmd_op);
          b_n   = cmd_b;
          cnt_n = cmd_count;
          err_n = 1'b0;
          if (cmd_load) acc_n = cmd_a;
          state_n = (cmd_count == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (req_ready) begin
          tmo_n = '0;
          if (rsp_valid) begin
            // Combinational responder: capture now and skip WAIT.
            capture = 1'b1;
            acc_n   = rsp_x;
            if (cnt != '0) cnt_n = cnt - CNT_W'(1);
            state_n = (cnt <= CNT_W'(1)) ? DONE : ISSUE;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (rsp_valid) begin
          capture = 1'b1;
          acc_n   = rsp_x;
          if (cnt != '0) cnt_n = cnt - CNT_W'(1);
          state_n = (cnt <= CNT_W'(1)) ? DONE : ISSUE;
        end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = DONE;
        end else begin
          tmo_n = tmo + TMO_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign req_valid = (state == ISSUE);
  assign req_op    = op_q;
  assign req_a     = acc;
  assign req_b     = b_q;
  assign done      = (state == DONE);
  assign result    = acc;
  assign err       = err_q;
  assign state_dbg = state;

`ifdef ALU_CHK_EN
  logic [WIDTH-1:0] ref_x;

  alu_ref_model u_ref (
    .op (req_op),
    .a  (req_a),
    .b  (req_b),
    .x  (ref_x)
  );

  // Sticky flag; only the first disagreeing response value is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_mismatch <= 1'b0;
      chk_bad_x    <= '0;
    end else if (capture && (rsp_x != ref_x)) begin
      chk_mismatch <= 1'b1;
      if (!chk_mismatch) chk_bad_x <= rsp_x;
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule
